bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//  Device-side master port for the shared bus arbiter. Accepts a one-shot command
//  (virtual address, read/write, burst) from local logic and raises req. It drives
//  the ctrl and address phases while acked, then streams write data out or read data
//  in, and drops req when the burst completes. One instance sits on each master slot.
// PARAMETERS
//  BUS_WIDTH   32   width of bus_in/bus_out, cmd_addr, wr_data, rd_data
//  CTRL_WIDTH  8    width of ctrl_in/ctrl_out
//  TIMEOUT     255  max cycles waiting for ack or for a non-wait cycle; 0 = disabled
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  reset      in   1           synchronous, active-high
//  cmd_valid  in   1           local command request
//  cmd_ready  out  1           high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_addr   in   BUS_WIDTH   virtual start address
//  cmd_we     in   1           1 = write, 0 = read
//  cmd_burst  in   3           burst code; word count = cmd_burst + 1 (1..8)
//  wr_data    in   BUS_WIDTH   current write word; must be valid from DATA entry
//  wr_pop     out  1           1-cycle pulse: wr_data consumed, present next word
//  rd_data    out  BUS_WIDTH   captured read word
//  rd_valid   out  1           1-cycle pulse with each rd_data word
//  done       out  1           1-cycle pulse at end of transfer (normal or error)
//  error      out  1           1-cycle pulse with done when the transfer timed out
//  req        out  1           bus request to arbiter (registered)
//  ack        in   1           this slot's grant from arbiter
//  ctrl_out   out  CTRL_WIDTH  {3'b000, burst, we, wait=0} in REQ/ADDR, else 0
//  ctrl_in    in   CTRL_WIDTH  broadcast ctrl bus; bit0 = WAIT
//  bus_out    out  BUS_WIDTH   address in ADDR/HOLD, write word in DATA(we), else 0
//  bus_in     in   BUS_WIDTH   broadcast data bus
// BEHAVIOUR
//  - Reset: state IDLE; req, wr_pop, rd_valid, done, error = 0; rd_data = 0; cmd
//    regs cleared; cmd_ready = 1 in the first cycle after reset. Reset mid-transfer
//    drops req next edge; no done pulse.
//  - IDLE: on accept, latch addr/we/burst, clear word and timeout counters -> REQ;
//    req = 1 from the next cycle.
//  - REQ: drive ctrl_out. On ack = 1 (first grant cycle; arbiter latches ctrl) -> ADDR.
//  - ADDR: drive bus_out = addr and keep ctrl_out. ack is expected high -> HOLD
//    unconditionally.
//  - HOLD: one cycle. The arbiter hands the grant to the slave and holds the address.
//    bus_out = addr -> DATA.
//  - DATA: a beat occurs on each cycle with ctrl_in[0] = 0.
//    - Write beat: bus_out = wr_data, wr_pop = 1.
//    - Read beat: rd_data <= bus_in, rd_valid = 1 next cycle.
//    - The beat that makes count == burst+1 -> DONE. req falls on that edge.
//  - DONE: req = 0, done = 1 for one cycle -> IDLE. The next cmd is accepted
//    earliest the cycle after DONE, so there is a min 1 idle req-low cycle between
//    transfers.
//  - Timeout: the counter runs in REQ (no ack) and in DATA (WAIT high) and resets on
//    progress. On reaching TIMEOUT: -> DONE with error = 1; req drops.
//  - Word counter is 4 bits, no wrap. cmd_* is ignored outside IDLE.
//  - Simultaneous: an ack in the same cycle as timeout expiry counts as ack
//    (progress wins).
// STRUCTURE
//  - Shared bus_pkg: CTRL_WAIT_BIT=0, CTRL_WE_BIT=1, CTRL_BURST_LSB=2,
//    CTRL_BURST_W=3, state encodings IDLE..DONE (3 bits).
//  - Sub-module bus_timeout_counter (clear, en, expired; width from TIMEOUT).
//  - FSM: next-state and output logic kept separate; all outputs registered except
//    cmd_ready, ctrl_out, bus_out, wr_pop.
// TESTING
//  - Write burst=3, addr 0x0000_1000, data 0xA0..0xA3, WAIT=0 -> req 1 for ack
//    +6 cycles; four wr_pop; done; bus_out = 0xA0..0xA3.
//  - Read burst=0, slave data 0xDEADBEEF, WAIT high 2 cycles -> one rd_valid with
//    0xDEADBEEF, then done.
//  - Arbiter withholds ack, TIMEOUT=8 -> req drops 8 cycles after REQ entry;
//    done=1 and error=1 together.
//  - reset=1 in DATA mid-burst -> req=0 next cycle, no done, cmd_ready=1.
//  - Back-to-back cmd_valid held high -> second accept only after the DONE cycle;
//    req low >= 1 cycle.
//  - burst=7 write -> exactly 8 wr_pop, ctrl_out[4:2]=3'b111 during REQ/ADDR.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port: ctrl field layout, FSM state
// encoding and the latched command attributes.
package bus_pkg;

  localparam int unsigned CTRL_WAIT_BIT  = 0;
  localparam int unsigned CTRL_WE_BIT    = 1;
  localparam int unsigned CTRL_BURST_LSB = 2;
  localparam int unsigned CTRL_BURST_W   = 3;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned WORD_CNT_W     = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_HOLD = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [CTRL_BURST_W-1:0] burst;
  } cmd_attr_t;

endpackage

// File: rtl/bus_master_port_if.sv
// Master-slot side of the shared bus: request/grant plus the broadcast ctrl and
// data buses seen by one master port.
interface bus_master_port_if #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned CTRL_WIDTH = 8
);

  logic                  req;
  logic                  ack;
  logic [CTRL_WIDTH-1:0] ctrl_out;
  logic [CTRL_WIDTH-1:0] ctrl_in;
  logic [BUS_WIDTH-1:0]  bus_out;
  logic [BUS_WIDTH-1:0]  bus_in;

  modport master (
    output req, ctrl_out, bus_out,
    input  ack, ctrl_in, bus_in
  );

  modport slave (
    input  req, ctrl_out, bus_out,
    output ack, ctrl_in, bus_in
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Stall counter: counts consecutive enabled cycles and flags the cycle that
// reaches TIMEOUT. TIMEOUT = 0 never expires.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of stalled cycles already seen, so the TIMEOUT-th fires here
  assign expired = (TIMEOUT != 0) && en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Device-side bus master port: takes a local command, arbitrates for the shared
// bus, drives ctrl/address phases, then streams a burst of write or read words.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BUS_WIDTH-1:0]    cmd_addr,
  input  logic                    cmd_we,
  input  logic [CTRL_BURST_W-1:0] cmd_burst,
  input  logic [BUS_WIDTH-1:0]    wr_data,
  output logic                    wr_pop,
  output logic [BUS_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    error,
  bus_master_port_if.master       bus
);

  state_e                state;
  state_e                state_nx;
  logic [BUS_WIDTH-1:0]  addr_q;
  cmd_attr_t             cmd_q;
  logic [WORD_CNT_W-1:0] count_q;
  logic                  req_q;
  logic                  wait_c;
  logic                  beat_c;
  logic                  last_c;
  logic                  tmo_en_c;
  logic                  tmo_expired_c;
  logic [CTRL_WIDTH-1:0] ctrl_c;
  logic                  ctrl_in_unused;

  assign wait_c         = bus.ctrl_in[CTRL_WAIT_BIT];
  assign ctrl_in_unused = ^bus.ctrl_in[CTRL_WIDTH-1:1];
  assign beat_c         = (state == ST_DATA) && !wait_c;
  assign last_c         = beat_c && (count_q == WORD_CNT_W'(cmd_q.burst));
  assign tmo_en_c       = ((state == ST_REQ) && !bus.ack) || ((state == ST_DATA) && wait_c);

  // Any cycle that is not a stall counts as progress and restarts the count
  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmo_en_c),
    .en      (tmo_en_c),
    .expired (tmo_expired_c)
  );

  // Next-state logic; a grant or beat always takes priority over expiry
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (cmd_valid) state_nx = ST_REQ;
      ST_REQ: begin
        if (bus.ack)           state_nx = ST_ADDR;
        else if (tmo_expired_c) state_nx = ST_DONE;
      end
      ST_ADDR: state_nx = ST_HOLD;
      ST_HOLD: state_nx = ST_DATA;
      ST_DATA: begin
        if (last_c)             state_nx = ST_DONE;
        else if (tmo_expired_c) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rd_data  <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_nx;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      req_q    <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      if ((state == ST_IDLE) && cmd_valid) begin
        addr_q      <= cmd_addr;
        cmd_q.we    <= cmd_we;
        cmd_q.burst <= cmd_burst;
        count_q     <= '0;
      end
      if (beat_c) begin
        count_q <= count_q + WORD_CNT_W'(1);
      end
      if (beat_c && !cmd_q.we) begin
        rd_data  <= bus.bus_in;
        rd_valid <= 1'b1;
      end
      // Entering DONE other than on the final beat means a stall expired
      if ((state_nx == ST_DONE) && (state != ST_DONE)) begin
        done  <= 1'b1;
        error <= !last_c;
      end
    end
  end

  always_comb begin
    ctrl_c = '0;
    if ((state == ST_REQ) || (state == ST_ADDR)) begin
      ctrl_c[CTRL_BURST_LSB +: CTRL_BURST_W] = cmd_q.burst;
      ctrl_c[CTRL_WE_BIT]                    = cmd_q.we;
    end
  end

  always_comb begin
    bus.bus_out = '0;
    if ((state == ST_ADDR) || (state == ST_HOLD)) begin
      bus.bus_out = addr_q;
    end else if ((state == ST_DATA) && cmd_q.we) begin
      bus.bus_out = wr_data;
    end
  end

  assign cmd_ready    = (state == ST_IDLE);
  assign wr_pop       = beat_c && cmd_q.we;
  assign bus.req      = req_q;
  assign bus.ctrl_out = ctrl_c;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed scenarios plus randomized transfers checked
// against a transaction-level timing model.
module tb_bus_master_port;

  localparam int unsigned BW = 32;
  localparam int unsigned CW = 8;
  localparam int TMO = 8;
  localparam int BUDGET = 160;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [BW-1:0] cmd_addr;
  logic          cmd_we;
  logic [2:0]    cmd_burst;
  logic [BW-1:0] wr_data;
  logic          wr_pop;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          error;

  bus_master_port_if #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW)) sif ();

  bus_master_port #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_burst (cmd_burst),
    .wr_data   (wr_data),
    .wr_pop    (wr_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .error     (error),
    .bus       (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;

  logic [BW-1:0] wdata  [8];
  logic [BW-1:0] rdword [8];
  int            waits  [8];

  bit            obs_req   [BUDGET];
  bit            obs_ready [BUDGET];
  logic [CW-1:0] obs_ctrl  [BUDGET];
  logic [BW-1:0] obs_bus   [BUDGET];
  logic [BW-1:0] pop_q [$];
  logic [BW-1:0] rd_q  [$];
  int done_cyc, n_done, err_stray, req_cnt, req_first, req_last;
  bit err_at_done;
  int exp_last, exp_done, exp_beats;
  bit exp_err;

  // Transfer timeline from the protocol rules: cycle 0 issues the command, the
  // grant arrives after ack_delay stalled REQ cycles, then ADDR, HOLD and data.
  function automatic void model(input int ack_delay, input int words);
    int t;
    exp_err   = 1'b0;
    exp_beats = 0;
    if (ack_delay >= TMO) begin
      exp_last = TMO;
      exp_done = TMO + 1;
      exp_err  = 1'b1;
      return;
    end
    t = ack_delay + 4;
    for (int i = 0; i < words; i++) begin
      if (waits[i] >= TMO) begin
        exp_last = t + TMO - 1;
        exp_done = t + TMO;
        exp_err  = 1'b1;
        return;
      end
      t = t + waits[i] + 1;
      exp_beats++;
    end
    exp_last = t - 1;
    exp_done = t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_we      = 1'b0;
    cmd_burst   = '0;
    wr_data     = '0;
    sif.ack     = 1'b0;
    sif.ctrl_in = '0;
    sif.bus_in  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Acts as local logic plus arbiter/slave for one transfer and records what the port did
  task automatic run_txn(input logic [BW-1:0] addr, input logic we, input logic [2:0] burst,
                         input int ack_delay);
    int beat, wait_left, pops, words;
    words = int'(burst) + 1;
    pop_q.delete();
    rd_q.delete();
    done_cyc = -1; n_done = 0; err_stray = 0; req_cnt = 0; req_first = -1; req_last = -1;
    err_at_done = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      obs_req[i] = 1'b0; obs_ready[i] = 1'b0; obs_ctrl[i] = '0; obs_bus[i] = '0;
    end
    beat = 0; wait_left = waits[0]; pops = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      cmd_valid   = (c == 0);
      cmd_addr    = addr;
      cmd_we      = we;
      cmd_burst   = burst;
      wr_data     = (pops < 8) ? wdata[pops] : '0;
      sif.ack     = sif.req && (c > ack_delay);
      sif.ctrl_in = '0;
      sif.bus_in  = $urandom;
      if (c >= ack_delay + 4 && beat < words) begin
        if (wait_left > 0) begin
          sif.ctrl_in[0] = 1'b1;
          wait_left--;
        end else begin
          sif.bus_in = rdword[beat];
          beat++;
          wait_left = (beat < 8) ? waits[beat] : 0;
        end
      end
      @(negedge clk);
      obs_req[c]   = sif.req;
      obs_ready[c] = cmd_ready;
      obs_ctrl[c]  = sif.ctrl_out;
      obs_bus[c]   = sif.bus_out;
      if (sif.req) begin
        req_cnt++;
        if (req_first < 0) req_first = c;
        req_last = c;
      end
      if (wr_pop) begin
        pop_q.push_back(sif.bus_out);
        pops++;
      end
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          err_at_done = error;
        end
      end else if (error) begin
        err_stray++;
      end
      if (done_cyc >= 0 && c > done_cyc) break;
    end
    sif.ack     = 1'b0;
    sif.ctrl_in = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passes++;
    checks++; if ({sif.req, done, error, rd_valid, wr_pop} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000", {sif.req, done, error, rd_valid, wr_pop}); else passes++;
    checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passes++;
    checks++; if ({sif.ctrl_out, sif.bus_out} !== '0)
      $display("FAIL reset_bus_idle: got ctrl %h bus %h want 0", sif.ctrl_out, sif.bus_out); else passes++;
    for (int i = 0; i < 8; i++) begin rdword[i] = 32'h5A5A_0001 + 32'(i); waits[i] = 0; end
    run_txn(32'h0000_2000, 1'b0, 3'd1, 0);
    do_reset();
    @(negedge clk);
    checks++; if (rd_data !== '0) $display("FAIL reset_rd_data_after_read: got %h want 0", rd_data); else passes++;
  endtask

  task automatic test_write_burst();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) begin wdata[i] = 32'hA0 + 32'(i); waits[i] = 0; end
    run_txn(32'h0000_1000, 1'b1, 3'd3, 0);
    checks++; if (req_first !== 1 || req_cnt !== 7)
      $display("FAIL wr_req_window: got first %0d count %0d want 1 7", req_first, req_cnt); else passes++;
    checks++; if (pop_q.size() !== 4) $display("FAIL wr_pop_count: got %0d want 4", pop_q.size()); else passes++;
    bad = 0;
    for (int i = 0; i < pop_q.size() && i < 4; i++) if (pop_q[i] !== 32'hA0 + 32'(i)) bad++;
    checks++; if (bad !== 0) $display("FAIL wr_bus_data: got %0d wrong words want 0", bad); else passes++;
    checks++; if (done_cyc !== 8 || err_at_done !== 1'b0)
      $display("FAIL wr_done: got cycle %0d err %b want 8 0", done_cyc, err_at_done); else passes++;
    checks++; if (obs_ctrl[1] !== 8'h0E) $display("FAIL wr_ctrl_req: got %h want 0e", obs_ctrl[1]); else passes++;
    checks++; if (obs_bus[2] !== 32'h1000 || obs_bus[3] !== 32'h1000)
      $display("FAIL wr_addr_phase: got %h %h want 1000", obs_bus[2], obs_bus[3]); else passes++;
    checks++; if (obs_ctrl[3] !== 8'h00) $display("FAIL wr_ctrl_hold: got %h want 00", obs_ctrl[3]); else passes++;
  endtask

  task automatic test_read_wait();
    do_reset();
    for (int i = 0; i < 8; i++) waits[i] = 0;
    waits[0]  = 2;
    rdword[0] = 32'hDEADBEEF;
    run_txn(32'h0000_3000, 1'b0, 3'd0, 1);
    checks++; if (rd_q.size() !== 1) $display("FAIL rd_valid_count: got %0d want 1", rd_q.size()); else passes++;
    checks++; if (rd_q.size() > 0 && rd_q[0] !== 32'hDEADBEEF)
      $display("FAIL rd_data_word: got %h want deadbeef", rd_q[0]); else passes++;
    checks++; if (done_cyc !== 8 || err_at_done !== 1'b0)
      $display("FAIL rd_done: got cycle %0d err %b want 8 0", done_cyc, err_at_done); else passes++;
    checks++; if (req_cnt !== 7 || pop_q.size() !== 0)
      $display("FAIL rd_req_window: got req %0d pops %0d want 7 0", req_cnt, pop_q.size()); else passes++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 8; i++) waits[i] = 0;
    run_txn(32'h0000_4000, 1'b1, 3'd2, 100);
    checks++; if (req_last !== TMO || req_cnt !== TMO)
      $display("FAIL tmo_req_drop: got last %0d count %0d want %0d", req_last, req_cnt, TMO); else passes++;
    checks++; if (done_cyc !== TMO + 1 || err_at_done !== 1'b1)
      $display("FAIL tmo_done_error: got cycle %0d err %b want %0d 1", done_cyc, err_at_done, TMO + 1); else passes++;
    checks++; if (pop_q.size() !== 0 || err_stray !== 0)
      $display("FAIL tmo_side_effects: got pops %0d stray %0d want 0 0", pop_q.size(), err_stray); else passes++;
  endtask

  task automatic test_reset_mid();
    int got_done, got_req;
    do_reset();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_burst = 3'd7; cmd_addr = $urandom; wr_data = $urandom;
    sif.ctrl_in = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sif.ack   = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    sif.ack = 1'b0;
    @(negedge clk);
    checks++; if (sif.req !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL midreset_state: got req %b ready %b done %b want 0 1 0", sif.req, cmd_ready, done); else passes++;
    got_done = 0; got_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) got_done++;
      if (sif.req) got_req++;
    end
    checks++; if (got_done !== 0 || got_req !== 0)
      $display("FAIL midreset_quiet: got done %0d req %0d want 0 0", got_done, got_req); else passes++;
  endtask

  task automatic test_back_to_back();
    bit r_req [12];
    bit r_ready [12];
    bit r_done [12];
    int accepts;
    do_reset();
    cmd_we = 1'b1; cmd_burst = 3'd0; cmd_addr = $urandom; wr_data = $urandom;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cmd_valid   = (c <= 6);
      sif.ack     = sif.req;
      sif.ctrl_in = '0;
      @(negedge clk);
      r_req[c] = sif.req; r_ready[c] = cmd_ready; r_done[c] = done;
      if (cmd_valid && cmd_ready) accepts++;
    end
    cmd_valid = 1'b0;
    sif.ack   = 1'b0;
    checks++; if (accepts !== 2) $display("FAIL b2b_accepts: got %0d want 2", accepts); else passes++;
    checks++; if (r_done[5] !== 1'b1 || r_ready[5] !== 1'b0)
      $display("FAIL b2b_done_cycle: got done %b ready %b want 1 0", r_done[5], r_ready[5]); else passes++;
    checks++; if (r_ready[6] !== 1'b1) $display("FAIL b2b_second_accept: got ready %b want 1", r_ready[6]); else passes++;
    checks++; if (r_req[5] !== 1'b0 || r_req[6] !== 1'b0 || r_req[7] !== 1'b1)
      $display("FAIL b2b_req_gap: got %b%b%b want 001", r_req[5], r_req[6], r_req[7]); else passes++;
    checks++; if (r_done[11] !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", r_done[11]); else passes++;
  endtask

  task automatic test_burst8();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) begin wdata[i] = $urandom; waits[i] = int'($urandom_range(0, 2)); end
    run_txn(32'h0000_8000, 1'b1, 3'd7, 2);
    model(2, 8);
    checks++; if (pop_q.size() !== 8) $display("FAIL b8_pop_count: got %0d want 8", pop_q.size()); else passes++;
    bad = 0;
    for (int i = 0; i < pop_q.size() && i < 8; i++) if (pop_q[i] !== wdata[i]) bad++;
    checks++; if (bad !== 0) $display("FAIL b8_bus_data: got %0d wrong words want 0", bad); else passes++;
    bad = 0;
    for (int c = 1; c <= 4; c++) if (obs_ctrl[c] !== 8'h1E) bad++;
    checks++; if (bad !== 0) $display("FAIL b8_ctrl_burst: got %0d wrong cycles want 0", bad); else passes++;
    checks++; if (obs_ctrl[5] !== 8'h00) $display("FAIL b8_ctrl_hold: got %h want 00", obs_ctrl[5]); else passes++;
    checks++; if (done_cyc !== exp_done) $display("FAIL b8_done: got %0d want %0d", done_cyc, exp_done); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [BW-1:0] addr;
      logic          we;
      logic [2:0]    burst;
      logic [CW-1:0] exp_ctrl;
      int            ad, bad, got_beats, other;
      addr  = $urandom;
      we    = 1'($urandom_range(0, 1));
      burst = 3'($urandom_range(0, 7));
      ad    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO, TMO + 3)) : int'($urandom_range(0, 4));
      for (int i = 0; i < 8; i++) begin
        wdata[i]  = $urandom;
        rdword[i] = $urandom;
        waits[i]  = ($urandom_range(0, 15) == 0) ? TMO : int'($urandom_range(0, 3));
      end
      run_txn(addr, we, burst, ad);
      model(ad, int'(burst) + 1);
      exp_ctrl = CW'({burst, we, 1'b0});
      checks++; if (req_first !== 1 || req_last !== exp_last || req_cnt !== exp_last)
        $display("FAIL rnd%0d_req: got first %0d last %0d count %0d want 1 %0d %0d",
                 n, req_first, req_last, req_cnt, exp_last, exp_last); else passes++;
      checks++; if (done_cyc !== exp_done || n_done !== 1)
        $display("FAIL rnd%0d_done: got cycle %0d pulses %0d want %0d 1", n, done_cyc, n_done, exp_done); else passes++;
      checks++; if (err_at_done !== exp_err || err_stray !== 0)
        $display("FAIL rnd%0d_error: got %b stray %0d want %b 0", n, err_at_done, err_stray, exp_err); else passes++;
      got_beats = we ? pop_q.size() : rd_q.size();
      other     = we ? rd_q.size() : pop_q.size();
      checks++; if (got_beats !== exp_beats || other !== 0)
        $display("FAIL rnd%0d_beats: got %0d other %0d want %0d 0", n, got_beats, other, exp_beats); else passes++;
      bad = 0;
      for (int i = 0; i < got_beats && i < 8; i++) begin
        if (we && pop_q[i] !== wdata[i]) bad++;
        if (!we && rd_q[i] !== rdword[i]) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL rnd%0d_data: got %0d wrong words want 0", n, bad); else passes++;
      checks++; if (obs_ctrl[1] !== exp_ctrl)
        $display("FAIL rnd%0d_ctrl: got %h want %h", n, obs_ctrl[1], exp_ctrl); else passes++;
      if (ad < TMO) begin
        checks++; if (obs_bus[ad + 2] !== addr || obs_bus[ad + 3] !== addr)
          $display("FAIL rnd%0d_addr: got %h %h want %h", n, obs_bus[ad + 2], obs_bus[ad + 3], addr); else passes++;
      end
      if (done_cyc >= 0 && done_cyc + 1 < BUDGET) begin
        checks++; if (obs_ready[done_cyc] !== 1'b0 || obs_ready[done_cyc + 1] !== 1'b1)
          $display("FAIL rnd%0d_ready: got %b%b want 01", n, obs_ready[done_cyc], obs_ready[done_cyc + 1]); else passes++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    test_reset();
    test_write_burst();
    test_read_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_burst8();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
